// File: rtl/updown_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_pkg
// Shared definitions for the up/down modulo counter and its prescaler:
//   - bound_mode_e : boundary behaviour (wrap or saturate)
//   - DIR_UP/DIR_DOWN : encoding of the up_dn_i direction input
//   - clog2_safe() : bits needed to hold 0..value-1 (never less than 1)
// ---------------------------------------------------------------------------
package updown_mod_counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } bound_mode_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Minimum of one bit so a degenerate range (value <= 2) still yields a
   // legal vector width.
   function automatic int clog2_safe(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            bits = i + 1;
         end else begin
            bits = bits;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/updown_mod_counter_tick_prescaler.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_tick_prescaler
// Divides the enabled clock by PRESCALE and produces a step strobe.
// Ports:
//   clk_i   : system clock, rising edge
//   reset_i : synchronous active-high reset, clears the phase counter
//   en_i    : enable; the phase counter only advances while high
//   clr_i   : synchronous clear of the phase (driven by the counter load)
//   tick_o  : combinational single-cycle step strobe, qualified by en_i
// ---------------------------------------------------------------------------
module updown_mod_counter_tick_prescaler
   import updown_mod_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int PW = clog2_safe(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_prescale_check
      $error("PRESCALE must be at least 1");
   end

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   // Step strobe: last phase of the prescale period on an enabled clock.
   always_comb begin
      tick_o = en_i && (phase_q == LAST);
   end

   // Phase next-state: clear wins, otherwise advance/roll over while enabled.
   always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
         phase_d = '0;
      end else if (en_i) begin
         if (phase_q == LAST) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + PW'(1'b1);
         end
      end else begin
         phase_d = phase_q;
      end
   end

   // Phase register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Modulo-(MAX+1) up/down counter with synchronous load, count enable,
// programmable prescaler and selectable wrap/saturate boundary behaviour.
// Ports:
//   clk_i      : system clock, rising edge
//   reset_i    : synchronous active-high reset (count, tc and prescaler to 0)
//   en_i       : count enable, also gates the prescaler
//   up_dn_i    : direction, 1 = up, 0 = down, sampled every clock
//   load_i     : synchronous load strobe (beats en_i, loses to reset_i)
//   load_val_i : value to load, clamped to MAX
//   count_o    : registered count, always within 0..MAX
//   tc_o       : registered one-cycle terminal-count pulse, high together
//                with the wrapped or held boundary value
// ---------------------------------------------------------------------------
module updown_mod_counter
   import updown_mod_counter_pkg::*;
#(
   parameter int WIDTH    = 6,
   parameter int MAX      = 20,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             up_dn_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);

   if (WIDTH < clog2_safe(MAX + 1)) begin : g_width_check
      $error("WIDTH is too small to hold MAX");
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam bound_mode_e      MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

   logic             tick_s;
   logic [WIDTH-1:0] load_clamp_s;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;

   updown_mod_counter_tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i),
      .clr_i   (load_i),
      .tick_o  (tick_s)
   );

   // Loaded values above MAX are clamped so count never leaves 0..MAX.
   always_comb begin
      if (load_val_i > MAX_V) begin
         load_clamp_s = MAX_V;
      end else begin
         load_clamp_s = load_val_i;
      end
   end

   // Count/tc next-state: load beats step; tc only on a boundary step.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load_i) begin
         count_d = load_clamp_s;
      end else if (tick_s) begin
         case (up_dn_i)
            DIR_UP: begin
               // Explicit compare keeps non-power-of-2 MAX correct.
               if (count_q >= MAX_V) begin
                  tc_d    = 1'b1;
                  count_d = (MODE == MODE_SAT) ? MAX_V : '0;
               end else begin
                  count_d = count_q + WIDTH'(1'b1);
               end
            end
            DIR_DOWN: begin
               if (count_q == '0) begin
                  tc_d    = 1'b1;
                  count_d = (MODE == MODE_SAT) ? '0 : MAX_V;
               end else begin
                  count_d = count_q - WIDTH'(1'b1);
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end else begin
         count_d = count_q;
      end
   end

   // Count and terminal-count registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
// Directed bench for updown_mod_counter. Three instances:
//   dut_a : WIDTH=6, MAX=20, PRESCALE=1, wrap
//   dut_s : WIDTH=4, MAX=9,  PRESCALE=1, saturate
//   dut_p : WIDTH=6, MAX=20, PRESCALE=4, wrap
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic       a_rst, a_en, a_up, a_ld, a_tc;
   logic [5:0] a_lv, a_cnt;
   logic       s_rst, s_en, s_up, s_ld, s_tc;
   logic [3:0] s_lv, s_cnt;
   logic       p_rst, p_en, p_up, p_ld, p_tc;
   logic [5:0] p_lv, p_cnt;

   updown_mod_counter #(.WIDTH(6), .MAX(20), .PRESCALE(1), .SATURATE(0)) dut_a (
      .clk_i(clk), .reset_i(a_rst), .en_i(a_en), .up_dn_i(a_up),
      .load_i(a_ld), .load_val_i(a_lv), .count_o(a_cnt), .tc_o(a_tc));

   updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) dut_s (
      .clk_i(clk), .reset_i(s_rst), .en_i(s_en), .up_dn_i(s_up),
      .load_i(s_ld), .load_val_i(s_lv), .count_o(s_cnt), .tc_o(s_tc));

   updown_mod_counter #(.WIDTH(6), .MAX(20), .PRESCALE(4), .SATURATE(0)) dut_p (
      .clk_i(clk), .reset_i(p_rst), .en_i(p_en), .up_dn_i(p_up),
      .load_i(p_ld), .load_val_i(p_lv), .count_o(p_cnt), .tc_o(p_tc));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ct(input string tag, input logic [31:0] c, input logic t,
                         input logic [31:0] ec, input logic et);
      total++;
      assert (c === ec) else begin
         bad++;
         $error("FAIL %s count observed=%0d expected=%0d", tag, c, ec);
      end
      total++;
      assert (t === et) else begin
         bad++;
         $error("FAIL %s tc observed=%0b expected=%0b", tag, t, et);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_en = 1'b0; a_up = 1'b1; a_ld = 1'b0; a_lv = 6'd0;
      s_rst = 1'b1; s_en = 1'b0; s_up = 1'b1; s_ld = 1'b0; s_lv = 4'd0;
      p_rst = 1'b1; p_en = 1'b0; p_up = 1'b1; p_ld = 1'b0; p_lv = 6'd0;
      step();
      step();
      chk_ct("a_reset", 32'(a_cnt), a_tc, 32'd0, 1'b0);
      chk_ct("s_reset", 32'(s_cnt), s_tc, 32'd0, 1'b0);
      chk_ct("p_reset", 32'(p_cnt), p_tc, 32'd0, 1'b0);

      // Up count through the wrap: 1..20, 0 (tc), 1
      a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         step();
         chk_ct("a_upwrap", 32'(a_cnt), a_tc, 32'(k % 21), (k == 21));
      end
      a_en = 1'b0;
      step(); chk_ct("a_hold_en0", 32'(a_cnt), a_tc, 32'd1, 1'b0);

      // Down wrap and direction change
      a_en = 1'b1; a_ld = 1'b1; a_lv = 6'd2;
      step(); chk_ct("a_load2", 32'(a_cnt), a_tc, 32'd2, 1'b0);
      a_ld = 1'b0; a_up = 1'b0;
      step(); chk_ct("a_dn1", 32'(a_cnt), a_tc, 32'd1, 1'b0);
      step(); chk_ct("a_dn0", 32'(a_cnt), a_tc, 32'd0, 1'b0);
      step(); chk_ct("a_dnwrap", 32'(a_cnt), a_tc, 32'd20, 1'b1);
      step(); chk_ct("a_dn19", 32'(a_cnt), a_tc, 32'd19, 1'b0);
      a_up = 1'b1;
      step(); chk_ct("a_turn20", 32'(a_cnt), a_tc, 32'd20, 1'b0);
      step(); chk_ct("a_turnwrap", 32'(a_cnt), a_tc, 32'd0, 1'b1);

      // Load priority, clamp and reset over load
      a_ld = 1'b1; a_lv = 6'd63;
      step(); chk_ct("a_clamp", 32'(a_cnt), a_tc, 32'd20, 1'b0);
      a_lv = 6'd5;
      step(); chk_ct("a_load5", 32'(a_cnt), a_tc, 32'd5, 1'b0);
      a_rst = 1'b1; a_lv = 6'd7;
      step(); chk_ct("a_rst_over_ld", 32'(a_cnt), a_tc, 32'd0, 1'b0);

      // Reset during the tc cycle
      a_rst = 1'b0; a_lv = 6'd20;
      step(); chk_ct("a_load20", 32'(a_cnt), a_tc, 32'd20, 1'b0);
      a_ld = 1'b0;
      step(); chk_ct("a_wrap_tc", 32'(a_cnt), a_tc, 32'd0, 1'b1);
      a_rst = 1'b1;
      step(); chk_ct("a_rst_in_tc", 32'(a_cnt), a_tc, 32'd0, 1'b0);
      a_rst = 1'b0;
      step(); chk_ct("a_after_rst", 32'(a_cnt), a_tc, 32'd1, 1'b0);
      a_en = 1'b0;

      // Saturating instance: hold at 9 with tc, then hold at 0 with tc
      s_rst = 1'b0; s_en = 1'b1; s_up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk_ct("s_up_sat", 32'(s_cnt), s_tc, (k <= 9) ? 32'(k) : 32'd9, (k >= 10));
      end
      s_up = 1'b0;
      step(); chk_ct("s_dn8", 32'(s_cnt), s_tc, 32'd8, 1'b0);
      s_ld = 1'b1; s_lv = 4'd0;
      step(); chk_ct("s_load0", 32'(s_cnt), s_tc, 32'd0, 1'b0);
      s_ld = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_ct("s_dn_sat", 32'(s_cnt), s_tc, 32'd0, 1'b1);
      end
      s_up = 1'b1;
      step(); chk_ct("s_up1", 32'(s_cnt), s_tc, 32'd1, 1'b0);
      s_en = 1'b0;

      // Prescaler: one step per 4 enabled clocks
      p_rst = 1'b0; p_en = 1'b1; p_up = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_ct("p_div4", 32'(p_cnt), p_tc, 32'(k / 4), 1'b0);
      end
      step(); step();
      chk_ct("p_phase2", 32'(p_cnt), p_tc, 32'd2, 1'b0);
      p_en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_ct("p_en_low", 32'(p_cnt), p_tc, 32'd2, 1'b0);
      end
      p_en = 1'b1;
      step(); chk_ct("p_phase3", 32'(p_cnt), p_tc, 32'd2, 1'b0);
      step(); chk_ct("p_delayed", 32'(p_cnt), p_tc, 32'd3, 1'b0);

      // Load clears the prescaler phase
      step(); step();
      p_ld = 1'b1; p_lv = 6'd10;
      step(); chk_ct("p_load10", 32'(p_cnt), p_tc, 32'd10, 1'b0);
      p_ld = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_ct("p_ld_phase", 32'(p_cnt), p_tc, (k == 4) ? 32'd11 : 32'd10, 1'b0);
      end

      // Reset mid-prescale: first step 4 enabled clocks after release
      step(); step();
      p_rst = 1'b1;
      step(); chk_ct("p_rst_mid", 32'(p_cnt), p_tc, 32'd0, 1'b0);
      p_rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_ct("p_rst_phase", 32'(p_cnt), p_tc, (k == 4) ? 32'd1 : 32'd0, 1'b0);
      end

      // Direction change mid-prescale, then down wrap with one-cycle tc
      step(); step();
      p_up = 1'b0;
      step(); chk_ct("p_dir_mid", 32'(p_cnt), p_tc, 32'd1, 1'b0);
      step(); chk_ct("p_dir_step", 32'(p_cnt), p_tc, 32'd0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_ct("p_dnwrap", 32'(p_cnt), p_tc, (k >= 4) ? 32'd20 : 32'd0, (k == 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the fixed up-counter.
- Provides a modulo-(MAX+1) counter that runs up or down, with a synchronous load, a count enable and a programmable prescaler.
- Boundary behaviour is selectable: wrap or saturate.
- Used as a general event, timer or index counter; the one-cycle terminal-count pulse can be chained into further counters.

Parameters:
- WIDTH, 6: count width in bits. Must satisfy WIDTH >= clog2(MAX+1); otherwise elaboration error.
- MAX, 20: highest count value. The counter range is 0..MAX.
- PRESCALE, 1: number of enabled clocks per count step. Must be >= 1. 1 means step on every enabled clock.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; also gates the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down. Sampled each clock.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered, one cycle).

Behaviour:
- One clock domain. Reset is synchronous and active-high: when reset=1 at a rising clk edge, all state is cleared.
- Reset values: count=0, tc=0, prescaler=0.
- Priority on each edge: reset > load > step > hold.
- Load:
  - count <= min(load_val, MAX); tc <= 0; prescaler <= 0.
  - en is ignored in a load cycle.
- Prescaler:
  - An internal counter runs 0..PRESCALE-1 and advances only when en=1.
  - A step occurs on the edge where en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - When en=0, both the prescaler and count hold.
  - PRESCALE=1 means every en=1 edge is a step.
- Step, up (up_dn=1):
  - count<MAX: count <= count+1, tc <= 0.
  - count==MAX, SATURATE=0: count <= 0, tc <= 1.
  - count==MAX, SATURATE=1: count holds at MAX, tc <= 1.
- Step, down (up_dn=0):
  - count>0: count <= count-1, tc <= 0.
  - count==0, SATURATE=0: count <= MAX, tc <= 1.
  - count==0, SATURATE=1: count holds at 0, tc <= 1.
- tc timing:
  - tc is high for exactly the cycle following a boundary step, i.e. coincident with the wrapped or held count value.
  - tc is 0 on any edge that is not a boundary step, including edges where en=0.
- Direction changes mid-prescale take effect at the next step; the prescaler is not reset by them.
- Latency: count and tc update on the clk edge after the step condition. There are no combinational paths from inputs to outputs.
- Arithmetic is done in WIDTH bits. count never exceeds MAX, and non-power-of-2 MAX is handled by an explicit compare, not by natural overflow.
- Reset asserted mid-prescale or during a tc pulse clears everything on that edge; tc is 0 the next cycle.

Decomposition:
- Shared package, counter_pkg:
  - typedef for the boundary mode (MODE_WRAP, MODE_SAT), mapped to SATURATE;
  - localparams DIR_UP=1, DIR_DOWN=0;
  - function clog2_safe, used for the WIDTH check and for the prescaler width.
- Sub-module, tick_prescaler:
  - parameter PRESCALE;
  - ports clk, reset, en, clr, tick;
  - tick is a combinational, single-cycle, enable-qualified step strobe;
  - clr is driven by load.
- The top level holds the count/tc registers and the boundary logic.

Test Plan:
1. Reset and up-wrap: defaults, reset high for 2 cycles then low, en=1, up_dn=1 -> count 0,1,…,20, then 0, with tc=1 only in the cycle count=0 after 20. No X after reset.
2. Down-wrap and direction change: load_val=2, then up_dn=0, en=1 -> count 2,1,0,20 with tc on 20. Switching up_dn=1 at 19 gives 20, then 0 with tc=1.
3. Saturate: SATURATE=1, MAX=9. Count up to 9 and hold 3 more steps -> count stays 9, tc=1 on each of the 3 held steps. Same check down at 0.
4. Load priority and clamp: load=1 with en=1, load_val=63, MAX=20 -> count=20, tc=0. load_val=5 -> count=5. Load with reset=1 -> count=0.
5. Prescaler: PRESCALE=4, en=1 -> count steps every 4th clock. Drop en for 3 cycles mid-prescale -> step is delayed by exactly 3 clocks. load clears prescaler phase.
6. Mid-operation reset: assert reset in the tc cycle at wrap and in mid-prescale -> next cycle count=0, tc=0, and first step occurs PRESCALE enabled clocks after reset is released.
